// File: rtl/xor_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xor_stream_pkg
// Brief    : State encodings shared by the XOR stream parity block.
// Revision : 1.0 - initial release
// ============================================================================
package xor_stream_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        HOLD  = ST_HOLD
    } xsp_state_t;

endpackage
`default_nettype wire

// File: rtl/xor_stream_parity_xor_reduce.sv
`default_nettype none
// ============================================================================
// Module   : xor_reduce
// Brief    : WIDTH-input XOR reduction, the generalised 2-input XOR cell.
// Revision : 1.0 - initial release
// ============================================================================
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_bit
);

    assign out_bit = ^in_vec;

endmodule
`default_nettype wire

// File: rtl/xor_stream_parity.sv
`default_nettype none
// ============================================================================
// Module   : xor_stream_parity
// Brief    : Folds framed valid/ready word streams into XOR, parity, length
//            and overflow results, one registered result per frame.
// Revision : 1.0 - initial release
// ============================================================================
module xor_stream_parity
    import xor_stream_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_xor,
    output logic             out_parity,
    output logic [LEN_W-1:0] out_len,
    output logic             out_ovf
);

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    xsp_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_xor_q, out_xor_d;
    logic             out_parity_q, out_parity_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic             out_ovf_q, out_ovf_d;
    logic             accept;
    logic             acc_par;

    // Gated by rst so no beat is taken while the block is being cleared.
    assign in_ready = !rst && (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    cnt_d   = LEN_W'(1);
                    mode_d  = odd_mode;
                    ovf_d   = 1'b0;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q ^ in_data;
                    if (cnt_q < MAX_CNT) begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Parity is taken on the next accumulator value so the result registers
    // load on the same edge that accepts the last beat.
    xor_reduce #(
        .WIDTH (WIDTH)
    ) u_xor_reduce (
        .in_vec  (acc_d),
        .out_bit (acc_par)
    );

    always_comb begin
        out_valid_d  = (state_d == HOLD);
        out_xor_d    = out_xor_q;
        out_parity_d = out_parity_q;
        out_len_d    = out_len_q;
        out_ovf_d    = out_ovf_q;
        if (accept && in_last) begin
            out_xor_d    = acc_d;
            out_parity_d = acc_par ^ mode_d;
            out_len_d    = cnt_d;
            out_ovf_d    = ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_xor_q    <= '0;
            out_parity_q <= 1'b0;
            out_len_q    <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_xor_q    <= out_xor_d;
            out_parity_q <= out_parity_d;
            out_len_q    <= out_len_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_xor    = out_xor_q;
    assign out_parity = out_parity_q;
    assign out_len    = out_len_q;
    assign out_ovf    = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_parity.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_stream_parity
// Brief    : Directed checks of xor_stream_parity at WIDTH 8, 1 and 32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_stream_parity;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        odd_mode;
    logic        out_ready;

    logic        in_ready, out_valid, out_parity, out_ovf;
    logic [7:0]  out_xor;
    logic [2:0]  out_len;

    logic        in_ready_w1, out_valid_w1, out_parity_w1, out_ovf_w1;
    logic [0:0]  out_xor_w1;
    logic [2:0]  out_len_w1;
    logic [0:0]  in_data_w1;

    logic        in_ready_w32, out_valid_w32, out_parity_w32, out_ovf_w32;
    logic [31:0] out_xor_w32;
    logic [2:0]  out_len_w32;
    logic [31:0] in_data_w32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign in_data_w1  = in_data[0:0];
    assign in_data_w32 = {4{in_data}};

    xor_stream_parity #(.WIDTH(8), .MAX_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_xor(out_xor),
        .out_parity(out_parity), .out_len(out_len), .out_ovf(out_ovf)
    );

    xor_stream_parity #(.WIDTH(1), .MAX_LEN(4)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w1),
        .in_data(in_data_w1), .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(out_valid_w1), .out_ready(out_ready), .out_xor(out_xor_w1),
        .out_parity(out_parity_w1), .out_len(out_len_w1), .out_ovf(out_ovf_w1)
    );

    xor_stream_parity #(.WIDTH(32), .MAX_LEN(4)) dut_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w32),
        .in_data(in_data_w32), .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(out_valid_w32), .out_ready(out_ready), .out_xor(out_xor_w32),
        .out_parity(out_parity_w32), .out_len(out_len_w32), .out_ovf(out_ovf_w32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Present one beat and hold it until the handshake completes.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic mode);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        odd_mode = mode;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
    endtask

    // Expected 8-bit values are hand-computed; the 1- and 32-bit instances
    // see bit 0 and four copies of the byte respectively.
    task automatic check_frame(input string tag, input logic [7:0] x, input logic p,
                               input logic [2:0] len, input logic ovf, input logic mode);
        check({tag, "_valid"},     32'(out_valid),      32'd1);
        check({tag, "_xor"},       32'(out_xor),        32'(x));
        check({tag, "_parity"},    32'(out_parity),     32'(p));
        check({tag, "_len"},       32'(out_len),        32'(len));
        check({tag, "_ovf"},       32'(out_ovf),        32'(ovf));
        check({tag, "_w1_xor"},    32'(out_xor_w1),     32'(x[0]));
        check({tag, "_w1_parity"}, 32'(out_parity_w1),  32'(x[0] ^ mode));
        check({tag, "_w32_xor"},   out_xor_w32,         {4{x}});
        check({tag, "_w32_parity"},32'(out_parity_w32), 32'(mode));
        check({tag, "_w32_len"},   32'(out_len_w32),    32'(len));
        if (out_ready) begin
            tick();
            check({tag, "_drop"},  32'(out_valid), 32'd0);
            check({tag, "_ready"}, 32'(in_ready),  32'd1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        odd_mode  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_xor",    32'(out_xor),    32'd0);
        check("rst_out_len",    32'(out_len),    32'd0);
        check("rst_out_ovf",    32'(out_ovf),    32'd0);
        check("rst_out_parity", 32'(out_parity), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Three-beat even frame
        send_beat(8'h0F, 1'b0, 1'b0);
        send_beat(8'h33, 1'b0, 1'b0);
        check("t1_no_early_valid", 32'(out_valid), 32'd0);
        send_beat(8'h55, 1'b1, 1'b0);
        check_frame("t1", 8'h69, 1'b0, 3'd1 + 3'd2, 1'b0, 1'b0);

        // Single-beat odd frame
        send_beat(8'h80, 1'b1, 1'b1);
        check_frame("t2", 8'h80, 1'b0, 3'd1, 1'b0, 1'b1);

        // Six beats into a four-beat counter
        for (int i = 0; i < 6; i++) send_beat(8'h01, (i == 5), 1'b0);
        check_frame("t3", 8'h00, 1'b0, 3'd4, 1'b1, 1'b0);

        // Consumer back-pressure while a new beat waits at the input
        out_ready = 1'b0;
        send_beat(8'hA5, 1'b0, 1'b0);
        send_beat(8'h5A, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_last  = 1'b1;
        odd_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_ready", 32'(in_ready),  32'd0);
            check("t4_hold_xor",   32'(out_xor),   32'hFF);
            check("t4_hold_len",   32'(out_len),   32'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t4_release_valid", 32'(out_valid), 32'd0);
        check("t4_release_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_frame("t4b", 8'h3C, 1'b1, 3'd1, 1'b0, 1'b1);

        // Reset in the middle of a frame
        send_beat(8'h12, 1'b0, 1'b0);
        send_beat(8'h34, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check("t5_rst_ready", 32'(in_ready),  32'd0);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_xor",   32'(out_xor),   32'd0);
        check("t5_rst_len",   32'(out_len),   32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_valid", 32'(out_valid), 32'd0);
        end
        send_beat(8'hAA, 1'b1, 1'b0);
        check_frame("t5", 8'hAA, 1'b0, 3'd1, 1'b0, 1'b0);

        // Idle gaps and mid-frame mode changes
        send_beat(8'h01, 1'b0, 1'b1);
        idle(2);
        send_beat(8'h02, 1'b0, 1'b0);
        idle(1);
        send_beat(8'h04, 1'b1, 1'b0);
        check_frame("t6a", 8'h07, 1'b0, 3'd3, 1'b0, 1'b1);

        send_beat(8'hFF, 1'b0, 1'b0);
        idle(3);
        send_beat(8'h0F, 1'b0, 1'b1);
        send_beat(8'hF0, 1'b0, 1'b1);
        send_beat(8'h3C, 1'b1, 1'b1);
        check_frame("t6b", 8'h3C, 1'b0, 3'd4, 1'b0, 1'b0);

        send_beat(8'h80, 1'b0, 1'b1);
        send_beat(8'h40, 1'b0, 1'b0);
        idle(1);
        send_beat(8'h20, 1'b0, 1'b0);
        send_beat(8'h10, 1'b0, 1'b1);
        send_beat(8'h08, 1'b1, 1'b0);
        check_frame("t6c", 8'hF8, 1'b0, 3'd4, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
